// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter/sequencer sharing one UART transmitter between
//   NUM_REQ requesters. A granted requester's byte and frame config are
//   latched and held on tx_data_o/tx_conf_o for the whole frame. A one-cycle
//   req_done_o pulse is returned to the owner once the transmitter reports
//   completion.
//
//   Optional feature: define UART_TX_ARB_TIMEOUT_EN to enable a watchdog that
//   aborts a frame stuck in START/XFER for 2^TIMEOUT_WIDTH-1 cycles.
//
// Ports
//   clk_i, rst_ni   clock, async active-low reset
//   tx_en_i         global enable, gates new grants only
//   req_valid_i     per-requester request (held until its ready pulse)
//   req_data_i      packed data, requester i at [i*MAX_DATA_WIDTH +: MAX_DATA_WIDTH]
//   req_conf_i      packed config {data[1:0], stop[1:0], parity_en}, same packing
//   req_ready_o     one-hot accept pulse (first START cycle)
//   req_done_o      one-hot frame-complete pulse (DONE cycle)
//   tx_en_o         passthrough of tx_en_i
//   tx_start_o      start request, held until tx_busy_i is seen
//   tx_data_o       latched frame data
//   tx_conf_o       latched frame config
//   tx_busy_i       transmitter busy
//   tx_done_i       transmitter done level (rising edge ends the frame)
//   grant_idx_o     current/last granted requester
//   active_o        high outside IDLE
//   timeout_o       watchdog abort pulse (tied 0 without the macro)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for tx_en_i and a valid request
// START  | tx_start_o high until the transmitter reports busy
// XFER   | frame in flight, waiting for a rising edge of tx_done_i
// DONE   | one cycle, req_done_o pulse to the owner

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_IDX_WIDTH  = 2,
  parameter int MAX_DATA_WIDTH = 8,
  parameter int CONF_WIDTH     = 5,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              tx_en_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*MAX_DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ*CONF_WIDTH-1:0]     req_conf_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [NUM_REQ-1:0]                req_done_o,
  output logic                              tx_en_o,
  output logic                              tx_start_o,
  output logic [MAX_DATA_WIDTH-1:0]         tx_data_o,
  output logic [CONF_WIDTH-1:0]             tx_conf_o,
  input  logic                              tx_busy_i,
  input  logic                              tx_done_i,
  output logic [REQ_IDX_WIDTH-1:0]          grant_idx_o,
  output logic                              active_o,
  output logic                              timeout_o
);

  localparam int SW = REQ_IDX_WIDTH + 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || REQ_IDX_WIDTH != $clog2(NUM_REQ) ||
      TIMEOUT_WIDTH < 2) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                     r_state;
  logic [REQ_IDX_WIDTH-1:0]   r_ptr;
  logic [REQ_IDX_WIDTH-1:0]   r_grant;
  logic                       r_done_q;
  logic                       r_start;
  logic                       r_active;
  logic                       r_timeout;
  logic [NUM_REQ-1:0]         r_ready;
  logic [NUM_REQ-1:0]         r_req_done;
  logic [MAX_DATA_WIDTH-1:0]  r_data;
  logic [CONF_WIDTH-1:0]      r_conf;

  logic [REQ_IDX_WIDTH-1:0]   w_win;
  logic [SW-1:0]              w_sum;
  logic                       w_grant;
  logic                       w_done_rise;
  logic                       w_abort;

  // Search from the largest offset down so the smallest offset above the
  // pointer (i.e. the next requester in round-robin order) wins last.
  always_comb begin
    w_win = r_ptr;
    w_sum = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_sum = {1'b0, r_ptr} + SW'(k);
      if (w_sum >= SW'(NUM_REQ)) begin
        w_sum = w_sum - SW'(NUM_REQ);
      end
      if (req_valid_i[w_sum[REQ_IDX_WIDTH-1:0]]) begin
        w_win = w_sum[REQ_IDX_WIDTH-1:0];
      end
    end
  end

  assign w_grant     = tx_en_i && (|req_valid_i);
  // Only a fresh 0->1 transition counts; a level left high from the
  // previous frame must not end the next one.
  assign w_done_rise = tx_done_i && !r_done_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] r_cnt;

  // Held at zero in IDLE so it starts from zero on entry to START.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if (r_state == ST_START || r_state == ST_XFER) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Abort on the edge at which the counter reaches all-ones.
  assign w_abort = (r_cnt == {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0});
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_ptr      <= REQ_IDX_WIDTH'(NUM_REQ - 1);
      r_grant    <= '0;
      r_done_q   <= 1'b0;
      r_start    <= 1'b0;
      r_active   <= 1'b0;
      r_timeout  <= 1'b0;
      r_ready    <= '0;
      r_req_done <= '0;
      r_data     <= '0;
      r_conf     <= '0;
    end else begin
      r_done_q   <= tx_done_i;
      r_ready    <= '0;
      r_req_done <= '0;
      r_timeout  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state  <= ST_START;
            r_start  <= 1'b1;
            r_active <= 1'b1;
            r_ready  <= NUM_REQ'(1) << w_win;
            r_grant  <= w_win;
            r_ptr    <= w_win;
            r_data   <= req_data_i[w_win*MAX_DATA_WIDTH +: MAX_DATA_WIDTH];
            r_conf   <= req_conf_i[w_win*CONF_WIDTH +: CONF_WIDTH];
          end
        end

        ST_START: begin
          if (w_abort) begin
            r_state   <= ST_IDLE;
            r_start   <= 1'b0;
            r_active  <= 1'b0;
            r_timeout <= 1'b1;
          end else if (tx_busy_i) begin
            r_state <= ST_XFER;
            r_start <= 1'b0;
          end
        end

        ST_XFER: begin
          if (w_abort) begin
            r_state   <= ST_IDLE;
            r_active  <= 1'b0;
            r_timeout <= 1'b1;
          end else if (w_done_rise) begin
            r_state    <= ST_DONE;
            r_req_done <= NUM_REQ'(1) << r_grant;
          end
        end

        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_start  <= 1'b0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign tx_en_o     = tx_en_i;
  assign tx_start_o  = r_start;
  assign tx_data_o   = r_data;
  assign tx_conf_o   = r_conf;
  assign req_ready_o = r_ready;
  assign req_done_o  = r_req_done;
  assign grant_idx_o = r_grant;
  assign active_o    = r_active;
  assign timeout_o   = r_timeout;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmit module between NUM_REQ independent requesters.
- Accepts a byte plus frame configuration from each requester over a valid/ready handshake.
- Drives the transmitter's start/data/conf inputs and holds them stable for the whole frame.
- Returns a per-requester completion pulse. Sits between the host-side UART sources and the transmit module.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_IDX_WIDTH, 2, width of grant index; set to $clog2(NUM_REQ).
- MAX_DATA_WIDTH, 8, data width per frame.
- CONF_WIDTH, 5, frame config width {data[1:0], stop[1:0], parity_en}.
- TIMEOUT_WIDTH, 16, watchdog counter width (optional feature only).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset.
- tx_en_i  in  1  global enable; gates new arbitration.
- req_valid_i  in  NUM_REQ  per-requester request; held with data/conf until its ready pulse.
- req_data_i  in  NUM_REQ*MAX_DATA_WIDTH  packed data; requester i at [i*MAX_DATA_WIDTH +: MAX_DATA_WIDTH].
- req_conf_i  in  NUM_REQ*CONF_WIDTH  packed config, same packing.
- req_ready_o  out  NUM_REQ  one-cycle accept pulse, one-hot.
- req_done_o  out  NUM_REQ  one-cycle frame-complete pulse, one-hot.
- tx_en_o  out  1  combinational copy of tx_en_i to transmitter.
- tx_start_o  out  1  start request to transmitter.
- tx_data_o  out  MAX_DATA_WIDTH  latched frame data.
- tx_conf_o  out  CONF_WIDTH  latched frame config.
- tx_busy_i  in  1  transmitter busy.
- tx_done_i  in  1  transmitter done; may stay high for many clk cycles.
- grant_idx_o  out  REQ_IDX_WIDTH  index of current/last granted requester.
- active_o  out  1  high outside IDLE.
- timeout_o  out  1  watchdog abort pulse.

Interface rule: one clock; reset is asynchronous and active-low (clk_i, rst_ni).

Behaviour:
- Reset (async, rst_ni low):
  - FSM to IDLE.
  - All outputs 0 except tx_en_o, which stays a passthrough of tx_en_i.
  - Round-robin pointer to NUM_REQ-1, so requester 0 has first priority.
  - tx_done_i edge register cleared.
  - Reset mid-frame abandons the frame silently; no req_done_o.
- All state is registered. States: IDLE, START, XFER, DONE.
- IDLE, grant:
  - Condition: tx_en_i=1 and any req_valid_i bit set.
  - Winner is the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - On that edge, latch the winner's data/conf into tx_data_o/tx_conf_o, set grant_idx_o, set pointer to winner, go to START.
  - req_ready_o[winner]=1 for exactly the first START cycle.
  - Latency: valid seen at edge N -> ready and tx_start_o high from edge N.
- IDLE, no grant:
  - tx_en_i=0 blocks all grants; valid requests wait.
- START:
  - tx_start_o=1 until tx_busy_i=1 is sampled.
  - Then tx_start_o=0 on the next cycle and go to XFER.
- XFER:
  - tx_data_o/tx_conf_o held stable.
  - Exits on a rising edge of tx_done_i (registered previous value) -> DONE.
  - A tx_done_i level already high on entry is ignored.
- DONE:
  - Lasts 1 cycle with req_done_o[grant_idx_o]=1, then IDLE.
  - Back-to-back: a new grant is possible the cycle after DONE.
- tx_en_i dropped mid-frame: the current frame completes normally; no new grant.
- req_valid_i drop before grant: the request is simply not considered. Drop after grant: no effect.
- Simultaneous requests: strict round-robin, so a continuously requesting source is served at least once every NUM_REQ frames.
- tx_data_o/tx_conf_o retain the last values in IDLE.

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- When defined:
  - Counter clears on entry to START and increments each clk in START/XFER.
  - At all-ones (2^TIMEOUT_WIDTH-1), drop tx_start_o, pulse timeout_o for 1 cycle, and return to IDLE.
  - No req_done_o is issued for the aborted frame; the pointer remains at the aborted index.
- When undefined: no counter; timeout_o tied 0; START/XFER wait indefinitely.

Test Plan:
1. Reset: rst_ni=0 mid-XFER -> all outputs 0 immediately. After release, with req_valid_i=4'b1111, the first grant goes to requester 0.
2. Single request: req_valid_i=4'b0100, data 8'hA5, conf 5'b11001 -> req_ready_o=4'b0100 one cycle, tx_data_o=8'hA5, tx_conf_o=5'b11001. tx_start_o is held until busy, then falls. After tx_done_i rises, req_done_o=4'b0100 one cycle.
3. Round-robin: req_valid_i=4'b1011 held for 4 frames -> grant order 0,1,3,0.
4. Enable gating: tx_en_i=0 with req_valid_i=4'b0001 -> no ready pulse. tx_en_i dropped during XFER -> frame completes with a done pulse and no further grant.
5. Long done level: tx_done_i held high for 50 clk across the DONE->IDLE->START transition -> exactly one req_done_o; the next frame waits for a fresh edge.
6. With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_WIDTH=4: tx_busy_i stuck 0 -> timeout_o pulses 15 cycles after START entry, returns to IDLE, no req_done_o.
